// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock.
// A horizontal pixel counter and a vertical line counter free-run. Sync,
// blanking, coordinates and line/frame strobes are decoded from the next
// counter value, so the registered outputs and the counters describe the
// same pixel in the same cycle.
// Optional feature macro: VGA_TIMING_OUTREG_EN adds one more output register
// stage. All outputs then shift together by +1 cycle, which matches a
// renderer that does a registered sprite-ROM lookup.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  localparam int unsigned CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_wrap;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Next counter values: h wraps at the end of a line, v steps only on that wrap.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + CW'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
    end
  end

  // Decode the pixel the counters are about to hold.
  always_comb begin
    hsync_d       = SYNC_IDLE;
    vsync_d       = SYNC_IDLE;
    video_on_d    = 1'b0;
    x_d           = h_d;
    y_d           = v_d;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if ((h_d >= HS_BEG) && (h_d < HS_END)) begin
      hsync_d = SYNC_ACTIVE;
    end
    if ((v_d >= VS_BEG) && (v_d < VS_END)) begin
      vsync_d = SYNC_ACTIVE;
    end
    video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
    line_start_d  = (h_d == '0);
    frame_start_d = (h_d == '0) && (v_d == '0);
  end

  // Counters sit on the last pixel in reset so the first edge lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= H_LAST;
      v_q <= V_LAST;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Primary output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_OUTREG_EN
  logic          hsync_p_q;
  logic          vsync_p_q;
  logic          video_on_p_q;
  logic [CW-1:0] x_p_q;
  logic [CW-1:0] y_p_q;
  logic          line_start_p_q;
  logic          frame_start_p_q;

  // Extra output stage; resets to the same values as the primary registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_p_q       <= SYNC_IDLE;
      vsync_p_q       <= SYNC_IDLE;
      video_on_p_q    <= 1'b0;
      x_p_q           <= '0;
      y_p_q           <= '0;
      line_start_p_q  <= 1'b0;
      frame_start_p_q <= 1'b0;
    end else begin
      hsync_p_q       <= hsync_q;
      vsync_p_q       <= vsync_q;
      video_on_p_q    <= video_on_q;
      x_p_q           <= x_q;
      y_p_q           <= y_q;
      line_start_p_q  <= line_start_q;
      frame_start_p_q <= frame_start_q;
    end
  end

  assign hsync       = hsync_p_q;
  assign vsync       = vsync_p_q;
  assign video_on    = video_on_p_q;
  assign x           = x_p_q;
  assign y           = y_p_q;
  assign line_start  = line_start_p_q;
  assign frame_start = frame_start_p_q;
`else
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance plus a small-raster,
// active-high-sync instance (so whole frames, vsync and wraps fit in a short
// run), sharing one reset. Expected outputs come from pixel arithmetic on the
// number of edges since reset release.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  // Small raster: 15 x 10 total, 8 x 6 visible, active-high sync.
  localparam int unsigned SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int unsigned SVA = 6, SVF = 1, SVS = 2, SVB = 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } vga_out_t;

  typedef struct packed {
    vga_out_t a;
    vga_out_t b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   mon_en = 1'b0;

  logic       hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
  logic [9:0] x_a, y_a;
  logic       hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
  logic [9:0] x_b, y_b;

  exp_t        sb_q[$];
  int unsigned k = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .video_on    (video_on_a),
    .x           (x_a),
    .y           (y_a),
    .line_start  (line_start_a),
    .frame_start (frame_start_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_ACTIVE(1'b1)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .video_on    (video_on_b),
    .x           (x_b),
    .y           (y_b),
    .line_start  (line_start_b),
    .frame_start (frame_start_b)
  );

  function automatic vga_out_t rst_out(input bit sa);
    vga_out_t o;
    o = '0;
    o.hs = ~sa;
    o.vs = ~sa;
    return o;
  endfunction

  // Reference: edge kk after release shows raster pixel kk-LAT (reset values before that).
  function automatic vga_out_t model(input int unsigned kk,
                                     input int unsigned ha, input int unsigned hf,
                                     input int unsigned hs, input int unsigned hb,
                                     input int unsigned va, input int unsigned vf,
                                     input int unsigned vs, input int unsigned vb,
                                     input bit sa);
    vga_out_t o;
    int unsigned ht, vt, p, h, v;
    if (kk < LAT) return rst_out(sa);
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = kk - LAT;
    h  = p % ht;
    v  = (p / ht) % vt;
    o.hs  = (h >= ha + hf && h < ha + hf + hs) ? sa : ~sa;
    o.vs  = (v >= va + vf && v < va + vf + vs) ? sa : ~sa;
    o.von = (h < ha) && (v < va);
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp_v, k, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input vga_out_t act, input vga_out_t e);
    chk({tag, ".hsync"}, int'(act.hs), int'(e.hs));
    chk({tag, ".vsync"}, int'(act.vs), int'(e.vs));
    chk({tag, ".video_on"}, int'(act.von), int'(e.von));
    chk({tag, ".x"}, int'(act.x), int'(e.x));
    chk({tag, ".y"}, int'(act.y), int'(e.y));
    chk({tag, ".line_start"}, int'(act.ls), int'(e.ls));
    chk({tag, ".frame_start"}, int'(act.fs), int'(e.fs));
  endtask

  // One clock of stimulus; queues the expected response for every DUT observation.
  task automatic step(input bit r);
    exp_t e;
    @(negedge clk);
    if (r && !reset) begin
      e.a = rst_out(1'b0);
      e.b = rst_out(1'b1);
      sb_q.push_back(e);
      mon_en = 1'b1;
      reset  = 1'b1;
    end else begin
      reset = r;
    end
    @(posedge clk);
    if (reset) k = 0;
    else k++;
    e.a = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    e.b = model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1);
    sb_q.push_back(e);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic hold_reset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1);
  endtask

  // Monitor: samples after every clock edge and right after an async reset assert.
  initial begin
    exp_t     e;
    vga_out_t act_a, act_b;
    forever begin
      @(posedge clk or posedge reset);
      if (mon_en) begin
        #2;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: got empty queue expected an entry (t=%0t)", $time);
        end else begin
          e     = sb_q.pop_front();
          act_a = {hsync_a, vsync_a, video_on_a, x_a, y_a, line_start_a, frame_start_a};
          act_b = {hsync_b, vsync_b, video_on_b, x_b, y_b, line_start_b, frame_start_b};
          cmp_out("std", act_a, e.a);
          cmp_out("small", act_b, e.b);
          n_tests++;
          if (y_b >= 10'(SVA + SVF + SVS + SVB)) begin
            n_fail++;
            $display("FAIL small.y_range: got %0d expected below %0d", y_b, SVA + SVF + SVS + SVB);
          end
        end
      end
    end
  end

  initial begin
    hold_reset(3);
    run(1700);
    // Park the standard raster on pixel (300,1), then reset for 3 cycles.
    hold_reset(3);
    run(800 + 300 + LAT);
    hold_reset(3);
    run(900);
    for (int i = 0; i < 6; i++) begin
      hold_reset($urandom_range(1, 3));
      run($urandom_range(50, 900));
    end
    run(500);
    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the divided pixel clock (25 MHz, the DCM CLKDV output of the clock-divider stage). It runs two registered counters, a horizontal pixel counter and a vertical line counter, and decodes sync, blanking, pixel coordinates and frame/line strobes from them. It sits directly downstream of the clock divider and feeds the asteroid/ship renderer and the VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync when asserted (0 = active-low)

Ports:
- clk  input  1  pixel clock (clkdiv2 from the divider)
- reset  input  1  asynchronous, active-high reset
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE
- video_on  output  1  high while the current pixel is in the visible area
- x  output  10  horizontal count of the current pixel
- y  output  10  vertical count of the current pixel
- line_start  output  1  one-cycle pulse at h = 0
- frame_start  output  1  one-cycle pulse at h = 0, v = 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525. All counts are 10-bit unsigned.
- h counts 0..H_TOTAL-1 and wraps to 0. v increments only when h wraps, counts 0..V_TOTAL-1 and wraps to 0. Both wrap in the same cycle at (799,524) to (0,0).
- Decode, applied to the counter value presented:
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]
  - vsync asserted for v in [490,491]
  - video_on = (h < 640) && (v < 480)
  - x = h, y = v, raw and not clamped; they are meaningful to consumers only while video_on = 1
  - line_start = (h == 0); frame_start = (h == 0 && v == 0)
- All outputs are registered. They are decoded from the next counter value so that outputs and counters describe the same pixel in the same cycle.
- Reset (asynchronous assert, synchronous release by clk):
  - internal h = 799, v = 524
  - hsync = vsync = !SYNC_ACTIVE, video_on = 0, line_start = 0, frame_start = 0, x = 0, y = 0
- Reset asserted mid-frame immediately forces the reset values above. The raster restarts from pixel (0,0) with no partial-frame recovery.
- No stall or enable input. The block free-runs on every clk edge.

## Timing
- First clk edge after reset deasserts: outputs present pixel (0,0), with video_on = 1, line_start = 1, frame_start = 1, hsync/vsync inactive.
- Line period 800 cycles; frame period 420,000 cycles.
- hsync active 96 cycles per line; vsync active 1600 cycles (2 lines) per frame, beginning at the line_start of line 490.
- Zero cycles latency from counter to outputs (base build); see Configuration.

## Configuration
- Macro VGA_TIMING_OUTREG_EN.
  - Defined: every output passes through one additional register stage, so all outputs shift together by +1 cycle. The first pixel (0,0) appears on the second edge after reset release. The added stage resets to the same values as the primary outputs. This aligns sync with a renderer that does a registered sprite-ROM lookup.
  - Undefined: outputs come straight from the primary registers, with timing as stated above.

## Test plan
- Reset release -> first edge: x=0, y=0, video_on=1, frame_start=1, hsync=vsync=1 (active-low default); with VGA_TIMING_OUTREG_EN, the same values appear one edge later.
- Run one line -> hsync low exactly at x=656 through x=751 (96 cycles); video_on falls at x=640; line_start pulses every 800 cycles.
- Run one frame -> vsync low for lines 490–491 (1600 cycles); video_on low for all of y ≥ 480; frame_start pulses once per 420,000 cycles.
- Wrap check -> at (799,524) the next edge gives (0,0), frame_start=1, and no y=525 is ever observed.
- Assert reset at (300,200) for 3 cycles -> outputs immediately take reset values; after release, the first pixel is (0,0).
- Override SYNC_ACTIVE=1 -> hsync/vsync polarity inverted, with identical edge positions.
